coproc_instr_decoder: RTL and testbench
=======================================

# coproc_instr_decoder

Receive-side front end of the matrix coprocessor. It accepts 22-bit instruction words from the button-stepped instruction source, then decodes the opcode and matrix/row/column/data fields. It turns each word into element-memory writes and reads, or into a start/done handshake with the operation unit. A 16-bit result register drives the four 7-segment digits.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles for op_done before abort (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  22  instruction word; fields [21:20] reserved/ignored, [19:12] data byte (signed), [11:10] matrix select, [9:7] row, [6:4] column, [3:0] opcode
- instr_valid  in  1  debounced level strobe; its 0→1 transition offers instr
- instr_ready  out  1  high when state is IDLE
- mem_we  out  1  element write strobe, one cycle
- mem_re  out  1  element read strobe, one cycle
- mem_addr  out  8  {matrix select, row, column}
- mem_wdata  out  8  data byte
- mem_rdata  in  8  read data, valid the cycle after mem_re
- op_start  out  1  operation launch strobe, one cycle
- op_code  out  4  latched opcode; valid while op_start or WAIT
- op_msel  out  2  latched matrix select
- op_done  in  1  operation complete; sampled only in WAIT
- op_result  in  16  operation result; captured with op_done
- result  out  16  display value
- error  out  1  last instruction illegal or timed out
- overrun  out  1  sticky: an offer was dropped while busy
- instr_count  out  8  accepted-instruction counter

## Operation
- Edge detect: prev_valid <= instr_valid every cycle. An offer is instr_valid & ~prev_valid.
  - Offer in IDLE: accepted. instr latched into instr_q; instr_count +1, wrapping 255→0; error cleared; go to DECODE.
  - Offer outside IDLE: dropped and overrun set. Overrun clears only on rst.
- Opcodes: 0000 NOP, 0001 LOAD, 0010 STORE, 0011–1001 operations (passed to the operation unit unchanged), 1010–1111 illegal.
- States: IDLE, DECODE, WRITE, READ, CAPTURE, EXEC, WAIT.
  - DECODE:
    - NOP → IDLE.
    - STORE → WRITE.
    - LOAD → READ.
    - Operation → EXEC.
    - Illegal → IDLE with error=1 and no strobe.
  - WRITE: mem_we=1, mem_addr and mem_wdata from instr_q → IDLE.
  - READ: mem_re=1 → CAPTURE.
  - CAPTURE: result <= sign-extended mem_rdata ({{8{d[7]}},d}) → IDLE.
  - EXEC: op_start=1 → WAIT; cycle counter cleared.
  - WAIT:
    - op_done=1 → result <= op_result, then IDLE.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without done → error=1, result unchanged, IDLE.
    - op_done asserted outside WAIT is ignored.
- Strobes are Moore outputs decoded from the state register and are low in all other states. mem_addr, mem_wdata, op_code and op_msel reflect instr_q at all times.
- A new offer arriving on the same edge that WAIT/CAPTURE/WRITE returns to IDLE is dropped (overrun=1), because the state is not yet IDLE when sampled.

## Timing
- Reset values:
  - state IDLE.
  - instr_ready=1 from the first cycle after the reset edge.
  - mem_we, mem_re and op_start 0.
  - result 16'h0000, error 0, overrun 0, instr_count 0, instr_q 0.
  - prev_valid 1, so an instr_valid held high through reset is not accepted until it falls and rises again.
- Reset mid-operation (any state): abort to IDLE on that edge. No further strobes; an outstanding op_done is ignored.
- Latency (offer sampled at edge N):
  - DECODE follows edge N.
  - STORE: mem_we high between edges N+1 and N+2; ready after N+2.
  - LOAD: mem_re between N+1 and N+2; result updated at N+3; ready after N+3.
  - Operation: op_start between N+1 and N+2; done sampled at edge M updates result at M; ready after M.
  - NOP/illegal: ready after N+1.
- Throughput: at most one instruction in flight; no queuing.

## Test plan
- Store: rst, then offer 22'b10_11111111_00_000_000_0010 → exactly one mem_we cycle with mem_addr 8'h00 and mem_wdata 8'hFF; instr_count=1; error=0. Then offer 22'b10_00000000_01_001_001_0010 → mem_addr 8'h49, mem_wdata 8'h00.
- Load: offer opcode 0001, addr 8'h49, with the memory model returning 8'h80 → one mem_re cycle; result=16'hFF80 two edges later; ready restored.
- Operation: offer opcode 0011 (sum); op_done pulsed 5 cycles after op_start with op_result 16'h1234 → single op_start, op_code 4'h3, result 16'h1234. A second offer during WAIT is dropped and overrun=1.
- Timeout and illegal, with TIMEOUT_CYCLES=16:
  - Opcode 0100 with op_done never asserted → error=1 after 16 WAIT cycles; result unchanged.
  - Next, opcode 1111 → no strobes and error=1.
  - A following NOP → error cleared.
- Reset and wrap:
  - Assert rst during WAIT → IDLE with all outputs at reset values; a later op_done has no effect.
  - Holding instr_valid high across reset yields no acceptance.
  - 256 NOPs wrap instr_count back to 0.

Source files
------------

// File: rtl/coproc_instr_decoder.sv
// Instruction front end of the matrix coprocessor: accepts button-stepped words,
// decodes them into element-memory accesses or operation-unit launches.
module coproc_instr_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        op_start,
  output logic [3:0]  op_code,
  output logic [1:0]  op_msel,
  input  logic        op_done,
  input  logic [15:0] op_result,
  output logic [15:0] result,
  output logic        error,
  output logic        overrun,
  output logic [7:0]  instr_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] EXEC    = 3'd5;
  localparam logic [2:0] WAIT    = 3'd6;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic          prev_valid;
  logic [21:0]   instr_q;
  logic [CW-1:0] cnt;
  logic          offer;
  logic [3:0]    opcode;
  logic          unused_reserved;

  assign offer           = instr_valid & ~prev_valid;
  assign opcode          = instr_q[3:0];
  assign unused_reserved = ^instr_q[21:20];

  assign instr_ready = (state == IDLE);
  assign mem_we      = (state == WRITE);
  assign mem_re      = (state == READ);
  assign op_start    = (state == EXEC);
  assign mem_addr    = instr_q[11:4];
  assign mem_wdata   = instr_q[19:12];
  assign op_code     = instr_q[3:0];
  assign op_msel     = instr_q[11:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prev_valid  <= 1'b1;
      instr_q     <= '0;
      cnt         <= '0;
      result      <= '0;
      error       <= 1'b0;
      overrun     <= 1'b0;
      instr_count <= '0;
    end else begin
      prev_valid <= instr_valid;
      // Offers are only taken in IDLE; anything arriving while busy is lost.
      if (offer && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (offer) begin
            instr_q     <= instr;
            instr_count <= instr_count + 8'd1;
            error       <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (opcode == 4'd0) begin
            state <= IDLE;
          end else if (opcode == 4'd1) begin
            state <= READ;
          end else if (opcode == 4'd2) begin
            state <= WRITE;
          end else if (opcode <= 4'd9) begin
            state <= EXEC;
          end else begin
            error <= 1'b1;
            state <= IDLE;
          end
        end
        WRITE:   state <= IDLE;
        READ:    state <= CAPTURE;
        CAPTURE: begin
          result <= {{8{mem_rdata[7]}}, mem_rdata};
          state  <= IDLE;
        end
        EXEC: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (op_done) begin
            result <= op_result;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coproc_instr_decoder.sv
// Scoreboard bench for coproc_instr_decoder: expected strobes are queued when an
// instruction is offered and matched when the DUT raises a strobe.
module tb_coproc_instr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        mem_we, mem_re;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        op_start;
  logic [3:0]  op_code;
  logic [1:0]  op_msel;
  logic        op_done = 1'b0;
  logic [15:0] op_result = '0;
  logic [15:0] result;
  logic        error, overrun;
  logic [7:0]  instr_count;

  always #5 clk = ~clk;

  coproc_instr_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .op_start(op_start), .op_code(op_code), .op_msel(op_msel),
    .op_done(op_done), .op_result(op_result), .result(result),
    .error(error), .overrun(overrun), .instr_count(instr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Element memory model with a preload port for the bench.
  logic [7:0] mem [256];
  logic       preload_en = 1'b0;
  logic [7:0] preload_addr = '0, preload_data = '0;
  always @(posedge clk) begin
    if (preload_en) mem[preload_addr] <= preload_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int         kind;   // 0 write, 1 read, 2 op start
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] code;
    logic [1:0] msel;
  } exp_t;
  exp_t sbq[$];

  task automatic expect_strobe(input int kind, input logic [7:0] addr, input logic [7:0] data,
                               input logic [3:0] code, input logic [1:0] msel);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.msel = msel;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (mem_we || mem_re || op_start)) begin
      if (sbq.size() == 0) begin
        check_eq("unexpected_strobe", {29'd0, mem_we, mem_re, op_start}, 32'd0);
      end else begin
        exp_t e;
        int   kind;
        e = sbq.pop_front();
        kind = mem_we ? 0 : (mem_re ? 1 : 2);
        check_eq("strobe_kind", kind, e.kind);
        check_eq("strobe_onehot", 32'(mem_we) + 32'(mem_re) + 32'(op_start), 32'd1);
        if (kind == 0) begin
          check_eq("wr_addr", mem_addr, e.addr);
          check_eq("wr_data", mem_wdata, e.data);
        end else if (kind == 1) begin
          check_eq("rd_addr", mem_addr, e.addr);
        end else begin
          check_eq("op_code", op_code, e.code);
          check_eq("op_msel", op_msel, e.msel);
        end
      end
    end
  end

  function automatic logic [21:0] mk(input logic [7:0] data, input logic [1:0] msel,
                                     input logic [2:0] row, input logic [2:0] col,
                                     input logic [3:0] op);
    return {2'b10, data, msel, row, col, op};
  endfunction

  task automatic offer(input logic [21:0] w);
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_strobe(input bit want_re, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (want_re ? mem_re : op_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_result", result, 16'h0000);
    check_eq("rst_error", error, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_count", instr_count, 0);

    // Stores
    expect_strobe(0, 8'h00, 8'hFF, 4'h2, 2'b00);
    offer(22'b10_11111111_00_000_000_0010);
    wait_ready("store1_ready");
    check_eq("store1_count", instr_count, 1);
    check_eq("store1_error", error, 0);
    expect_strobe(0, 8'h49, 8'h00, 4'h2, 2'b01);
    offer(22'b10_00000000_01_001_001_0010);
    wait_ready("store2_ready");
    check_eq("store2_count", instr_count, 2);

    // Load of a negative byte
    @(negedge clk);
    preload_en = 1'b1; preload_addr = 8'h49; preload_data = 8'h80;
    @(negedge clk);
    preload_en = 1'b0;
    expect_strobe(1, 8'h49, 8'h00, 4'h1, 2'b01);
    offer(mk(8'h00, 2'b01, 3'd1, 3'd1, 4'h1));
    wait_strobe(1'b1, "load_re_seen");
    @(negedge clk);
    check_eq("load_capture_busy", instr_ready, 0);
    @(negedge clk);
    check_eq("load_result", result, 16'hFF80);
    check_eq("load_ready", instr_ready, 1);

    // Operation with a dropped offer during WAIT
    expect_strobe(2, 8'h80, 8'h00, 4'h3, 2'b10);
    offer(mk(8'h00, 2'b10, 3'd0, 3'd0, 4'h3));
    wait_strobe(1'b0, "op_start_seen");
    offer(mk(8'h00, 2'b00, 3'd0, 3'd0, 4'h0));
    check_eq("op_busy", instr_ready, 0);
    repeat (3) @(negedge clk);
    op_done = 1'b1; op_result = 16'h1234;
    @(negedge clk);
    op_done = 1'b0;
    check_eq("op_result", result, 16'h1234);
    check_eq("op_ready", instr_ready, 1);
    check_eq("op_overrun", overrun, 1);
    check_eq("op_error", error, 0);
    check_eq("op_count", instr_count, 4);

    // Timeout after 16 WAIT cycles
    expect_strobe(2, 8'h00, 8'h00, 4'h4, 2'b00);
    offer(mk(8'h00, 2'b00, 3'd0, 3'd0, 4'h4));
    wait_strobe(1'b0, "to_start_seen");
    waits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_ready) break;
      waits++;
    end
    check_eq("to_wait_cycles", waits, 16);
    check_eq("to_error", error, 1);
    check_eq("to_result", result, 16'h1234);

    // Illegal then NOP
    offer(mk(8'h55, 2'b11, 3'd7, 3'd7, 4'hF));
    wait_ready("ill_ready");
    check_eq("ill_error", error, 1);
    check_eq("ill_count", instr_count, 6);
    offer(mk(8'h00, 2'b00, 3'd0, 3'd0, 4'h0));
    wait_ready("nop_ready");
    check_eq("nop_error", error, 0);
    check_eq("nop_count", instr_count, 7);

    // Reset during WAIT, late op_done ignored
    expect_strobe(2, 8'hC0, 8'h00, 4'h5, 2'b11);
    offer(mk(8'h00, 2'b11, 3'd0, 3'd0, 4'h5));
    wait_strobe(1'b0, "rst_op_start_seen");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_ready", instr_ready, 1);
    check_eq("mid_rst_result", result, 16'h0000);
    check_eq("mid_rst_overrun", overrun, 0);
    check_eq("mid_rst_count", instr_count, 0);
    check_eq("mid_rst_addr", mem_addr, 8'h00);
    check_eq("mid_rst_opcode", op_code, 4'h0);
    op_done = 1'b1; op_result = 16'hBEEF;
    @(negedge clk);
    op_done = 1'b0;
    @(negedge clk);
    check_eq("late_done_result", result, 16'h0000);
    check_eq("late_done_ready", instr_ready, 1);

    // instr_valid held high through reset
    instr = mk(8'h00, 2'b00, 3'd0, 3'd0, 4'h0);
    instr_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("held_valid_count", instr_count, 0);
    check_eq("held_valid_ready", instr_ready, 1);
    instr_valid = 1'b0;
    @(negedge clk);

    // 256 NOPs wrap the counter
    for (int i = 0; i < 256; i++) begin
      offer(mk(8'h00, 2'b00, 3'd0, 3'd0, 4'h0));
      wait_ready("wrap_ready");
      if (i == 254) check_eq("wrap_count_255", instr_count, 255);
    end
    check_eq("wrap_count_0", instr_count, 0);
    check_eq("wrap_overrun", overrun, 0);
    check_eq("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
